param_fwd_pipe: RTL and testbench
=================================

// Module: param_fwd_pipe
// PURPOSE
//  Parametrised 3-stage datapath: fetch/decode (S1), operand read (S2), ALU/writeback (S3).
//  Internal NUM_REGS x DW register file.
//  Adds per-stage valid bits, bubble insertion, a hard-zero register and full operand forwarding
//  (S2->S1 and S3->S1), so back-to-back dependent instructions need no stalls.
//  Sits at design top level and is driven directly by the instruction source.
// PARAMETERS
//  DW        32  datapath/register width (>=8)
//  NUM_REGS  32  architectural registers (2..32); addresses >= NUM_REGS read 0, writes dropped
//  ZERO_REG  1   1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  reset      in   1   asynchronous, active-low reset
//  instr_in   in   32  instruction, sampled when instr_valid=1
//  instr_valid in  1   1: instr_in is a real instruction; 0: inject bubble
//  dbg_sel    in   5   debug read address (combinational, reads committed regfile)
//  dbg_data   out  DW  regfile[dbg_sel]; 0 if dbg_sel >= NUM_REGS
//  out_data   out  DW  S3 ALU result register
//  out_valid  out  1   S3 holds a valid instruction this cycle
// BEHAVIOUR
//  Instruction fields:
//   [31] WE; [30] SRC (1=imm); [29:27] ALUOP; [25:21] RD; [20:16] RS1; [15:11] RS2; [15:0] IMM
//   [26] ignored
//  IMM is sign-extended to DW. Operand B = SRC ? sext(IMM) : reg[RS2].
//  ALUOP (a=RS1 operand, b=operand B; result DW bits, carries/overflow dropped):
//   000 ADD; 001 SUB; 010 AND; 011 OR; 100 XOR
//   101 SLT (signed, result 1/0)
//   110 SLL a by b[clog2(DW)-1:0]; 111 SRL (logical), same shift amount
//  Pipeline timing:
//   Edge k: S1 latches instr_in and v1 = instr_valid.
//   Edge k+1: S2 latches resolved operands and control, v2 = v1.
//   Edge k+2: S3 latches ALU result, RD, WE, v3 = v2.
//   Edge k+3: regfile[RD] <= out_data if v3 & WE & RD < NUM_REGS & !(ZERO_REG & RD==0).
//   Latency: out_data/out_valid valid after edge k+2; throughput 1 per clock.
//  Forwarding (evaluated during S1 read, per source RS1/RS2), priority:
//   1. S2 instr valid, WE, RD==RS -> combinational ALU result of S2.
//   2. else S3 valid, WE, RD==RS -> out_data.
//   3. else regfile[RS].
//   Never forward for RS==0 when ZERO_REG=1, or for RS >= NUM_REGS; these read 0.
//  Bubbles (valid=0) never write, never forward. out_data still updates, but with out_valid=0.
//  Same-edge regfile write and S1 read of the same register: forwarding rule 2 supplies the new value.
//  Reset (reset=0, async, takes effect immediately):
//   All regfile entries, stage registers, out_data and out_valid go to 0; in-flight instructions discarded.
//   First instruction sampled at the first rising edge with reset=1.
//  dbg_data reflects writes from the edge after commit (edge k+3); no forwarding.
// TESTING
//  T1 reset=0 mid-stream with 3 instrs in flight -> out_valid=0, out_data=0 immediately, all dbg reads 0.
//  T2 ADDI r1=r0+5; ADDI r2=r0+-3 (IMM 16'hFFFD), back-to-back ->
//     out_data 5 then 32'hFFFFFFFD; dbg r2=32'hFFFFFFFD.
//  T3 ADDI r1=r0+7; ADD r2=r1+r1; SUB r3=r2-r1, consecutive cycles ->
//     outputs 7, 14, 7 (S2 and S3 forwarding exercised).
//  T4 ADDI r4=r0+1; bubble; SLL r5=r4<<r4 ->
//     out_data 2; bubble cycle out_valid=0; r4 unchanged.
//  T5 ADDI r0=r0+9 then ADD r6=r0+r0 (ZERO_REG=1) -> r6=0, dbg r0=0.
//     Repeat with ZERO_REG=0 -> r6=18.
//  T6 NUM_REGS=8: ADDI r9=r0+3 then ADD r1=r9+r9 -> r1=0, no regfile write;
//     SLT r1 of -1 vs 1 = 1.

Source files
------------

// File: rtl/param_fwd_pipe.sv
// ---------------------------------------------------------------------------
// param_fwd_pipe
//   Three-stage integer datapath with an internal register file:
//     S1  fetch/decode   - latches the instruction and its valid bit, then
//                          resolves both source operands (with forwarding)
//     S2  operand read   - holds resolved operands and control; the ALU
//                          evaluates combinationally from this stage
//     S3  ALU/writeback  - holds the ALU result; commits it to the register
//                          file on the following edge
//   Forwarding from S2 (live ALU result) and S3 (out_data) lets dependent
//   instructions issue back-to-back with no stalls.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        asynchronous, active-low reset
//   instr_in     32-bit instruction word
//   instr_valid  1: instr_in is a real instruction, 0: bubble
//   dbg_sel      debug read address into the committed register file
//   dbg_data     regfile[dbg_sel], 0 when dbg_sel >= NUM_REGS
//   out_data     S3 ALU result register
//   out_valid    S3 holds a valid instruction
//
// Instruction word
//   [31] WE  [30] SRC(1=imm)  [29:27] ALUOP  [26] unused
//   [25:21] RD  [20:16] RS1  [15:11] RS2  [15:0] IMM (sign-extended)
// ---------------------------------------------------------------------------
module param_fwd_pipe #(
  parameter int DW       = 32,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instr_in,
  input  logic          instr_valid,
  input  logic [4:0]    dbg_sel,
  output logic [DW-1:0] dbg_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid
);

  localparam int SHW = $clog2(DW);

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  // S1 state
  logic [31:0]   instr1_q, instr1_d;
  logic          v1_q, v1_d;
  // S2 state
  logic [DW-1:0] a2_q, a2_d, b2_q, b2_d;
  alu_op_e       op2_q, op2_d;
  logic [4:0]    rd2_q, rd2_d;
  logic          we2_q, we2_d, v2_q, v2_d;
  // S3 state
  logic [DW-1:0] out_data_q, out_data_d;
  logic [4:0]    rd3_q, rd3_d;
  logic          we3_q, we3_d, v3_q, v3_d;
  // Register file
  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] regs_d [NUM_REGS];

  logic [DW-1:0] alu_res;
  logic [DW-1:0] rf_rs1, rf_rs2, dbg_rd;
  logic [DW-1:0] imm_ext;
  logic [4:0]    rs1, rs2;
  logic          unused_bit26;

  assign rs1          = instr1_q[20:16];
  assign rs2          = instr1_q[15:11];
  assign unused_bit26 = instr1_q[26];
  assign imm_ext      = DW'($signed(instr1_q[15:0]));

  // Addresses that always read as zero and are never forwarded.
  function automatic logic reads_zero(input logic [4:0] a);
    return (32'(a) >= NUM_REGS) || ((ZERO_REG != 0) && (a == 5'd0));
  endfunction

  // Operand resolution: S2 has priority because it is the younger producer.
  function automatic logic [DW-1:0] resolve(
    input logic [4:0]    rs,
    input logic [DW-1:0] rf_val,
    input logic          s2_en,
    input logic [4:0]    s2_rd,
    input logic [DW-1:0] s2_val,
    input logic          s3_en,
    input logic [4:0]    s3_rd,
    input logic [DW-1:0] s3_val
  );
    if (reads_zero(rs))               return '0;
    else if (s2_en && (s2_rd == rs))  return s2_val;
    else if (s3_en && (s3_rd == rs))  return s3_val;
    else                              return rf_val;
  endfunction

  // Register file read ports; looping over real entries keeps out-of-range
  // addresses at zero without indexing past the array.
  always_comb begin
    rf_rs1 = '0;
    rf_rs2 = '0;
    dbg_rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rs1 == 5'(i))     rf_rs1 = regs_q[i];
      if (rs2 == 5'(i))     rf_rs2 = regs_q[i];
      if (dbg_sel == 5'(i)) dbg_rd = regs_q[i];
    end
  end

  // ALU on S2 operands; carries and overflow are dropped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    alu_res = '0;
    unique case (op2_q)
      ALU_ADD: alu_res = a2_q + b2_q;
      ALU_SUB: alu_res = a2_q - b2_q;
      ALU_AND: alu_res = a2_q & b2_q;
      ALU_OR:  alu_res = a2_q | b2_q;
      ALU_XOR: alu_res = a2_q ^ b2_q;
      ALU_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(a2_q) < $signed(b2_q))};
      ALU_SLL: alu_res = a2_q << b2_q[SHW-1:0];
      ALU_SRL: alu_res = a2_q >> b2_q[SHW-1:0];
    endcase
  end

  // Next-state for every pipeline stage and the register file.
  always_comb begin
    instr1_d   = instr_in;
    v1_d       = instr_valid;

    a2_d       = resolve(rs1, rf_rs1, v2_q && we2_q, rd2_q, alu_res,
                         v3_q && we3_q, rd3_q, out_data_q);
    b2_d       = instr1_q[30] ? imm_ext
                              : resolve(rs2, rf_rs2, v2_q && we2_q, rd2_q, alu_res,
                                        v3_q && we3_q, rd3_q, out_data_q);
    op2_d      = alu_op_e'(instr1_q[29:27]);
    rd2_d      = instr1_q[25:21];
    we2_d      = instr1_q[31];
    v2_d       = v1_q;

    out_data_d = alu_res;
    rd3_d      = rd2_q;
    we3_d      = we2_q;
    v3_d       = v2_q;

    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (v3_q && we3_q && (rd3_q == 5'(i)) && !((ZERO_REG != 0) && (i == 0)))
        regs_d[i] = out_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr1_q   <= '0;
      v1_q       <= 1'b0;
      a2_q       <= '0;
      b2_q       <= '0;
      op2_q      <= ALU_ADD;
      rd2_q      <= '0;
      we2_q      <= 1'b0;
      v2_q       <= 1'b0;
      out_data_q <= '0;
      rd3_q      <= '0;
      we3_q      <= 1'b0;
      v3_q       <= 1'b0;
      // NOTE: the register file is architectural state that must read zero
      // after reset, so every entry is cleared rather than left undefined.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      instr1_q   <= instr1_d;
      v1_q       <= v1_d;
      a2_q       <= a2_d;
      b2_q       <= b2_d;
      op2_q      <= op2_d;
      rd2_q      <= rd2_d;
      we2_q      <= we2_d;
      v2_q       <= v2_d;
      out_data_q <= out_data_d;
      rd3_q      <= rd3_d;
      we3_q      <= we3_d;
      v3_q       <= v3_d;
      regs_q     <= regs_d;
    end
  end

  assign dbg_data  = dbg_rd;
  assign out_data  = out_data_q;
  assign out_valid = v3_q;

endmodule

// File: tb/tb_param_fwd_pipe.sv
// ---------------------------------------------------------------------------
// tb_param_fwd_pipe
//   Directed bench for param_fwd_pipe. Three instances share one instruction
//   stream: default parameters, ZERO_REG=0, and NUM_REGS=8. Inputs change and
//   outputs are sampled on the falling edge; an instruction driven at falling
//   edge t appears on out_data at falling edge t+3 and on dbg_data at t+4.
// ---------------------------------------------------------------------------
module tb_param_fwd_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic [4:0]  dbg_sel;

  logic [31:0] dbg_data, out_data;
  logic        out_valid;
  logic [31:0] dbg_nz, out_nz;
  logic        ov_nz;
  logic [31:0] dbg_n8, out_n8;
  logic        ov_n8;

  int vectors = 0;
  int errors  = 0;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [31:0] BUB   = 32'h0;

  always #5 clk = ~clk;

  param_fwd_pipe dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .out_data(out_data), .out_valid(out_valid)
  );

  param_fwd_pipe #(.ZERO_REG(0)) dut_nz (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .dbg_sel(dbg_sel), .dbg_data(dbg_nz), .out_data(out_nz), .out_valid(ov_nz)
  );

  param_fwd_pipe #(.NUM_REGS(8)) dut_n8 (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .dbg_sel(dbg_sel), .dbg_data(dbg_n8), .out_data(out_n8), .out_valid(ov_n8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ri(input logic [2:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [15:0] imm);
    return {1'b1, 1'b1, op, 1'b0, rd, rs1, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [2:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {1'b1, 1'b0, op, 1'b0, rd, rs1, rs2, 11'b0};
  endfunction

  task automatic cyc(input logic [31:0] ins, input logic v);
    @(negedge clk);
    instr_in    = ins;
    instr_valid = v;
  endtask

  task automatic bub();
    cyc(BUB, 1'b0);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] exp);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, exp);
  endtask

  task automatic set_dbg(input logic [4:0] sel);
    dbg_sel = sel;
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    instr_in    = '0;
    instr_valid = 1'b0;
    dbg_sel     = '0;
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_dbg_r0", dbg_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // T2: immediate adds, positive and sign-extended negative
    cyc(ri(OP_ADD, 5'd1, 5'd0, 16'd5), 1'b1);
    cyc(ri(OP_ADD, 5'd2, 5'd0, 16'hFFFD), 1'b1);
    bub();
    bub();  chk_out("t2_r1", 32'd5);
    bub();  chk_out("t2_r2", 32'hFFFF_FFFD);
    bub();
    check("t2_bubble_valid", {31'b0, out_valid}, 32'd0);
    set_dbg(5'd2); check("t2_dbg_r2", dbg_data, 32'hFFFF_FFFD);
    set_dbg(5'd1); check("t2_dbg_r1", dbg_data, 32'd5);

    // T3: back-to-back dependencies via S2 and S3 forwarding
    cyc(ri(OP_ADD, 5'd1, 5'd0, 16'd7), 1'b1);
    cyc(rr(OP_ADD, 5'd2, 5'd1, 5'd1), 1'b1);
    cyc(rr(OP_SUB, 5'd3, 5'd2, 5'd1), 1'b1);
    bub();  chk_out("t3_addi", 32'd7);
    bub();  chk_out("t3_add", 32'd14);
    bub();  chk_out("t3_sub", 32'd7);
    bub();
    set_dbg(5'd3); check("t3_dbg_r3", dbg_data, 32'd7);
    set_dbg(5'd2); check("t3_dbg_r2", dbg_data, 32'd14);

    // T4: bubble between producer and consumer
    cyc(ri(OP_ADD, 5'd4, 5'd0, 16'd1), 1'b1);
    bub();
    cyc(rr(OP_SLL, 5'd5, 5'd4, 5'd4), 1'b1);
    bub();  chk_out("t4_addi", 32'd1);
    bub();  check("t4_bubble_valid", {31'b0, out_valid}, 32'd0);
    bub();  chk_out("t4_sll", 32'd2);
    bub();
    set_dbg(5'd5); check("t4_dbg_r5", dbg_data, 32'd2);
    set_dbg(5'd4); check("t4_dbg_r4", dbg_data, 32'd1);

    // T5: writes to r0, hard-zero versus ordinary register
    cyc(ri(OP_ADD, 5'd0, 5'd0, 16'd9), 1'b1);
    cyc(rr(OP_ADD, 5'd6, 5'd0, 5'd0), 1'b1);
    bub();
    bub();  chk_out("t5_addi_r0", 32'd9);
    bub();
    chk_out("t5_add_zr", 32'd0);
    check("t5_add_nz", out_nz, 32'd18);
    bub();
    set_dbg(5'd6);
    check("t5_dbg_r6_zr", dbg_data, 32'd0);
    check("t5_dbg_r6_nz", dbg_nz, 32'd18);
    set_dbg(5'd0);
    check("t5_dbg_r0_zr", dbg_data, 32'd0);
    check("t5_dbg_r0_nz", dbg_nz, 32'd9);

    // T6: out-of-range register on NUM_REGS=8, then signed compare
    cyc(ri(OP_ADD, 5'd9, 5'd0, 16'd3), 1'b1);
    cyc(rr(OP_ADD, 5'd1, 5'd9, 5'd9), 1'b1);
    cyc(ri(OP_ADD, 5'd2, 5'd0, 16'hFFFF), 1'b1);
    cyc(ri(OP_ADD, 5'd3, 5'd0, 16'd1), 1'b1);
    check("t6_addi_r9_n8", out_n8, 32'd3);
    cyc(rr(OP_SLT, 5'd1, 5'd2, 5'd3), 1'b1);
    check("t6_add_r9_n8", out_n8, 32'd0);
    chk_out("t6_add_r9_full", 32'd6);
    set_dbg(5'd1); check("t6_no_alias_r1_n8", dbg_n8, 32'd7);
    bub();
    check("t6_m1_n8", out_n8, 32'hFFFF_FFFF);
    set_dbg(5'd1); check("t6_r1_zero_n8", dbg_n8, 32'd0);
    bub();  check("t6_p1_n8", out_n8, 32'd1);
    bub();
    check("t6_slt_n8_valid", {31'b0, ov_n8}, 32'd1);
    check("t6_slt_n8", out_n8, 32'd1);
    chk_out("t6_slt_full", 32'd1);
    bub();
    set_dbg(5'd1); check("t6_dbg_r1_n8", dbg_n8, 32'd1);
    set_dbg(5'd9);
    check("t6_dbg_r9_n8", dbg_n8, 32'd0);
    check("t6_dbg_r9_full", dbg_data, 32'd3);

    // T1: asynchronous reset with three instructions in flight
    cyc(ri(OP_ADD, 5'd7, 5'd0, 16'd11), 1'b1);
    cyc(ri(OP_ADD, 5'd8, 5'd0, 16'd12), 1'b1);
    cyc(ri(OP_ADD, 5'd10, 5'd0, 16'd13), 1'b1);
    bub();  chk_out("t1_pre_reset", 32'd11);
    #2 reset = 1'b0;
    #1;
    check("t1_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t1_rst_data", out_data, 32'd0);
    check("t1_rst_data_n8", out_n8, 32'd0);
    for (int s = 0; s < 32; s++) begin
      set_dbg(5'(s));
      check($sformatf("t1_dbg_r%0d", s), dbg_data, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    cyc(ri(OP_ADD, 5'd1, 5'd0, 16'd4), 1'b1);
    bub();  check("t1_post_v1", {31'b0, out_valid}, 32'd0);
    bub();  check("t1_post_v2", {31'b0, out_valid}, 32'd0);
    bub();  chk_out("t1_first_instr", 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
